// File: rtl/iot_pkg.sv
// ============================================================================
// Module   : iot_pkg
// Brief    : Shared constants for the IoT event scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package iot_pkg;

   localparam int N_DEV_DEFAULT = 8;
   localparam int ID_W_DEFAULT  = 3;
   localparam int DEBOUNCE_LEN  = 4;

   typedef enum logic {
      EV_LEAVE = 1'b0,
      EV_JOIN  = 1'b1
   } ev_dir_e;

   localparam ev_dir_e JOIN  = EV_JOIN;
   localparam ev_dir_e LEAVE = EV_LEAVE;

endpackage

`default_nettype wire

// File: rtl/iot_rr_arbiter.sv
// ============================================================================
// Module   : iot_rr_arbiter
// Brief    : Combinational round-robin picker, searching from i_last+1 upward.
// Revision : 1.0
// ============================================================================
`default_nettype none

module iot_rr_arbiter #(
   parameter int N    = 8,
   parameter int ID_W = 3
) (
   input  logic [N-1:0]    i_req,
   input  logic            i_en,
   input  logic [ID_W-1:0] i_last,
   output logic            o_valid,
   output logic [ID_W-1:0] o_idx
);

   logic [ID_W:0] w_cand;

   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      w_cand  = '0;
      for (int k = 1; k <= N; k++) begin
         // Sum never exceeds 2N-1, so one extra bit is enough before wrapping.
         w_cand = {1'b0, i_last} + (ID_W+1)'(k);
         if (w_cand >= (ID_W+1)'(N))
            w_cand = w_cand - (ID_W+1)'(N);
         if (!o_valid && i_en && i_req[w_cand[ID_W-1:0]]) begin
            o_valid = 1'b1;
            o_idx   = w_cand[ID_W-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/iot_event_scheduler.sv
// ============================================================================
// Module   : iot_event_scheduler
// Brief    : Serialises device online/offline changes into one event per cycle.
//            Optional input debounce enabled by macro IOT_DEBOUNCE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module iot_event_scheduler
   import iot_pkg::*;
#(
   parameter int N_DEV = N_DEV_DEFAULT,
   parameter int ID_W  = ID_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_DEV-1:0] dev_active,
   input  logic             hold,
   output logic             change,
   output logic             on_off,
   output logic [ID_W-1:0]  dev_id,
   output logic [ID_W:0]    pending_cnt
);

   logic [N_DEV-1:0] r_sync1;
   logic [N_DEV-1:0] r_sync2;
   logic [N_DEV-1:0] w_seen;
   logic [N_DEV-1:0] r_reported;
   logic [N_DEV-1:0] w_pending;
   logic [N_DEV-1:0] w_mask;
   logic [N_DEV-1:0] w_req;
   logic [ID_W-1:0]  r_last;
   logic             w_gnt_vld;
   logic [ID_W-1:0]  w_gnt_idx;
   logic [ID_W:0]    w_popcnt;

`ifdef IOT_DEBOUNCE_EN
   localparam int DEB_W = $clog2(DEBOUNCE_LEN);

   generate
      for (genvar g = 0; g < N_DEV; g++) begin : g_deb
         logic [DEB_W-1:0] r_cnt;
         logic             r_seen;

         // seen follows the synchronizer only after DEBOUNCE_LEN steady samples.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_cnt  <= '0;
               r_seen <= 1'b0;
            end else if (r_sync2[g] == r_seen) begin
               r_cnt  <= '0;
            end else if (r_cnt == DEB_W'(DEBOUNCE_LEN - 1)) begin
               r_cnt  <= '0;
               r_seen <= r_sync2[g];
            end else begin
               r_cnt  <= r_cnt + 1'b1;
            end
         end

         assign w_seen[g] = r_seen;
      end
   endgenerate
`else
   assign w_seen = r_sync2;
`endif

   assign w_pending = w_seen ^ r_reported;
   // Keep the device granted last cycle out of this cycle's search.
   assign w_mask    = change ? ({{(N_DEV-1){1'b0}}, 1'b1} << r_last) : '0;
   assign w_req     = w_pending & ~w_mask;

   always_comb begin
      w_popcnt = '0;
      for (int i = 0; i < N_DEV; i++)
         w_popcnt = w_popcnt + (ID_W+1)'(w_pending[i]);
   end

   iot_rr_arbiter #(
      .N    (N_DEV),
      .ID_W (ID_W)
   ) u_arb (
      .i_req   (w_req),
      .i_en    (~hold),
      .i_last  (r_last),
      .o_valid (w_gnt_vld),
      .o_idx   (w_gnt_idx)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1     <= '0;
         r_sync2     <= '0;
         r_reported  <= '0;
         r_last      <= ID_W'(N_DEV - 1);
         change      <= 1'b0;
         on_off      <= 1'b0;
         dev_id      <= '0;
         pending_cnt <= '0;
      end else begin
         r_sync1     <= dev_active;
         r_sync2     <= r_sync1;
         pending_cnt <= w_popcnt;
         change      <= w_gnt_vld;
         if (w_gnt_vld) begin
            on_off                <= w_seen[w_gnt_idx] ? JOIN : LEAVE;
            dev_id                <= w_gnt_idx;
            r_last                <= w_gnt_idx;
            r_reported[w_gnt_idx] <= w_seen[w_gnt_idx];
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/iot_event_scheduler.md
IOT_EVENT_SCHEDULER -- requirements
Module: iot_event_scheduler

Interface
REQ-001 SHALL have parameter N_DEV, default 8, meaning number of device status lines (2..16).
REQ-002 SHALL have parameter ID_W, default 3, meaning device index width, equal to clog2(N_DEV).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port dev_active, input, N_DEV bits: per-device level, 1 = online; asynchronous to clk.
REQ-006 SHALL have port hold, input, 1 bit: when 1, event issue is stalled by the downstream monitor.
REQ-007 SHALL have port change, output, 1 bit: one-cycle pulse meaning one device event is issued this cycle.
REQ-008 SHALL have port on_off, output, 1 bit: event direction, valid with change; 1 = join (count up), 0 = leave (count down).
REQ-009 SHALL have port dev_id, output, ID_W bits: index of the device the current event refers to, valid with change.
REQ-010 SHALL have port pending_cnt, output, ID_W+1 bits: number of devices with unreported status.

Function
REQ-011 SHALL sample dev_active into a two-flop synchronizer; the second stage is the "seen" vector.
REQ-012 SHALL keep a "reported" vector holding the status last issued downstream for each device.
REQ-013 SHALL treat device i as pending whenever seen[i] differs from reported[i].
REQ-014 SHALL, in each cycle with hold=0 and at least one pending device, grant exactly one device via round-robin, starting the search at the index after the last grant, wrapping at N_DEV-1 to 0.
REQ-015 SHALL, on a grant of device i, register change=1, on_off=seen[i], dev_id=i, and set reported[i] to seen[i] in the same edge.
REQ-016 SHALL drive change=0 in every cycle with no grant, hold on_off and dev_id at their last values, and never assert change in two consecutive cycles for the same device.
REQ-017 SHALL give a latency of 3 clk edges from a dev_active transition to the change pulse, when the device is uncontended and hold=0.
REQ-018 SHALL issue no event for a device whose level toggles and returns before it is granted; this is net-zero cancellation.
REQ-019 SHALL, while hold=1, issue no grant, leave the round-robin pointer unchanged, and keep tracking pending devices.
REQ-020 SHALL, when all N_DEV devices change simultaneously, issue N_DEV events on N_DEV consecutive unheld cycles, one per device, in round-robin order.
REQ-021 SHALL update pending_cnt every cycle as the registered popcount of the pending vector.

Reset
REQ-022 SHALL, while rst=0, asynchronously clear the synchronizer, reported vector, round-robin pointer (next search starts at 0), change, on_off, dev_id and pending_cnt.
REQ-023 SHALL, on a reset asserted mid-operation, discard all pending events; after release, devices already online are reported as joins.

Configuration
REQ-024 SHALL, with macro IOT_DEBOUNCE_EN defined, require the synchronized level to be stable for 4 consecutive cycles before updating seen; uncontended latency becomes 7 edges, and shorter pulses are ignored.
REQ-025 SHALL, without IOT_DEBOUNCE_EN, update seen directly from the synchronizer as in REQ-011.

Structure
REQ-026 SHALL place N_DEV and ID_W defaults, the debounce length constant (4) and the event-direction constants (JOIN=1, LEAVE=0) in shared package iot_pkg.
REQ-027 SHALL implement the round-robin grant as sub-module iot_rr_arbiter, with inputs request vector, enable and last-grant index, and outputs grant valid and grant index.

Verification
REQ-028 SHALL cover single join: rst released, dev_active=8'h04 at cycle 0 -> change=1, on_off=1, dev_id=2 at edge 3, pending_cnt back to 0.
REQ-029 SHALL cover join then leave: dev_active 8'h00->8'h01, then 8'h00 10 cycles later -> two pulses, on_off 1 then 0, dev_id=0 both times.
REQ-030 SHALL cover simultaneous burst: dev_active 8'h00->8'hFF -> 8 consecutive change pulses, dev_id 0..7, all on_off=1, pending_cnt counting down 8..0.
REQ-031 SHALL cover hold: burst of 8'h0F with hold=1 for 5 cycles -> no change while held, pending_cnt=4, then 4 pulses after hold=0.
REQ-032 SHALL cover cancellation: device 3 pulsed high for 1 cycle while hold=1 -> no event issued for device 3 after hold drops.
REQ-033 SHALL cover reset mid-burst: rst=0 during the 8'hFF burst at event 3 -> outputs 0 immediately; after release, 8 fresh joins with dev_id starting at 0.
